mem_resp_router: RTL and testbench

//  Response-side steering unit for the shared memory port. The request side selects
//  one of two sources: 0 = instruction fetch, 1 = data access. This block routes each

---
 rtl/mem_resp_router.sv | 112 +++++++++++
 tb/tb_mem_resp_router.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_resp_router.sv
// Response steering for the shared memory port: records the source ID of every
// accepted request in order and routes each returning response to that source.
module mem_resp_router #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_src,
    output logic             req_ready,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    output logic [PTR_W:0]   outstanding,
    output logic             err
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             out0_valid_q, out0_valid_d;
    logic             out1_valid_q, out1_valid_d;
    logic [WIDTH-1:0] out0_data_q, out0_data_d;
    logic [WIDTH-1:0] out1_data_q, out1_data_d;
    logic             err_q, err_d;

    logic push, pop, empty, pop_src;

    assign empty     = (count_q == '0);
    assign req_ready = (count_q != FULL_CNT);
    assign push      = req_valid & req_ready;
    // A response arriving while empty can never belong to a same-cycle request.
    assign pop       = resp_valid & ~empty;
    assign pop_src   = fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out0_valid_d = 1'b0;
        out1_valid_d = 1'b0;
        out0_data_d  = out0_data_q;
        out1_data_d  = out1_data_q;
        err_d        = err_q | (resp_valid & empty);

        if (push) begin
            fifo_d[wr_ptr_q] = req_src;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (pop_src) begin
                out1_valid_d = 1'b1;
                out1_data_d  = resp_data;
            end else begin
                out0_valid_d = 1'b1;
                out0_data_d  = resp_data;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out0_valid_q <= 1'b0;
            out1_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out1_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out0_valid_q <= out0_valid_d;
            out1_valid_q <= out1_valid_d;
            out0_data_q  <= out0_data_d;
            out1_data_q  <= out1_data_d;
            err_q        <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign out0_valid  = out0_valid_q;
    assign out0_data   = out0_data_q;
    assign out1_valid  = out1_valid_q;
    assign out1_data   = out1_data_q;
    assign outstanding = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_resp_router.sv
// Self-checking bench for mem_resp_router: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_mem_resp_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_src;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        out0_valid;
    logic [15:0] out0_data;
    logic        out1_valid;
    logic [15:0] out1_data;
    logic [2:0]  outstanding;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit          m_q[$];
    bit          m_v0, m_v1, m_err;
    logic [15:0] m_d0, m_d1;

    mem_resp_router #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_src     (req_src),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .out0_valid  (out0_valid),
        .out0_data   (out0_data),
        .out1_valid  (out1_valid),
        .out1_data   (out1_data),
        .outstanding (outstanding),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        check("req_ready",   32'(req_ready),   32'(m_q.size() != 4));
        check("outstanding", 32'(outstanding), 32'(m_q.size()));
        check("out0_valid",  32'(out0_valid),  32'(m_v0));
        check("out1_valid",  32'(out1_valid),  32'(m_v1));
        check("out0_data",   32'(out0_data),   32'(m_d0));
        check("out1_data",   32'(out1_data),   32'(m_d1));
        check("err",         32'(err),         32'(m_err));
    endtask

    // Called at a falling edge: apply inputs, advance the model, clock, then check.
    task automatic step(input bit r, input bit rv, input bit rs, input bit pv, input logic [15:0] pd);
        bit s;
        bit was_empty;
        bit can_push;
        rst        = r;
        req_valid  = rv;
        req_src    = rs;
        resp_valid = pv;
        resp_data  = pd;
        if (r) begin
            m_q.delete();
            m_v0 = 0; m_v1 = 0; m_err = 0;
            m_d0 = '0; m_d1 = '0;
        end else begin
            was_empty = (m_q.size() == 0);
            can_push  = (m_q.size() < 4);
            m_v0 = 0; m_v1 = 0;
            if (pv && was_empty) m_err = 1;
            if (pv && !was_empty) begin
                s = m_q.pop_front();
                if (s) begin m_v1 = 1; m_d1 = pd; end
                else   begin m_v0 = 1; m_d0 = pd; end
            end
            if (rv && can_push) m_q.push_back(rs);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_src = 0; resp_valid = 0; resp_data = '0;
        m_v0 = 0; m_v1 = 0; m_err = 0; m_d0 = '0; m_d1 = '0;
        @(negedge clk);

        // reset
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        idle();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outst", 32'(outstanding), 32'd0);

        // routing in order
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'hAAAA);
        check("rt_v0", 32'(out0_valid), 32'd1);
        check("rt_d0", 32'(out0_data), 32'hAAAA);
        step(0, 0, 0, 1, 16'hBBBB);
        check("rt_v1a", 32'(out1_valid), 32'd1);
        check("rt_d1a", 32'(out1_data), 32'hBBBB);
        step(0, 0, 0, 1, 16'hCCCC);
        check("rt_d1b", 32'(out1_data), 32'hCCCC);
        check("rt_d0h", 32'(out0_data), 32'hAAAA);
        idle();

        // full
        for (int i = 0; i < 4; i++) step(0, 1, i[0], 0, 16'h0);
        check("full_cnt", 32'(outstanding), 32'd4);
        check("full_rdy", 32'(req_ready), 32'd0);
        step(0, 1, 1, 0, 16'h0);
        check("full_drop", 32'(outstanding), 32'd4);
        step(0, 0, 0, 1, 16'h1111);
        check("full_pop", 32'(outstanding), 32'd3);
        check("full_rdy1", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'(16'h2000 + i));

        // wrap with simultaneous push and pop
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 10; i++) step(0, 1, i[0], 1, 16'(16'h3000 + i));
        check("wrap_cnt", 32'(outstanding), 32'd2);
        step(0, 0, 0, 1, 16'h4000);
        step(0, 0, 0, 1, 16'h4001);
        idle();

        // underflow
        step(0, 0, 0, 1, 16'h5555);
        check("uf_err", 32'(err), 32'd1);
        check("uf_v", 32'({out0_valid, out1_valid}), 32'd0);
        step(0, 1, 1, 1, 16'h6666);
        check("uf_push", 32'(outstanding), 32'd1);
        idle();
        check("uf_sticky", 32'(err), 32'd1);

        // mid-operation reset
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        check("mr_cnt", 32'(outstanding), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        step(0, 0, 0, 1, 16'h7777);
        check("mr_err1", 32'(err), 32'd1);

        // random traffic
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < 55),
                 1'($urandom),
                 ($urandom_range(0, 99) < 45),
                 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
